// File: rtl/cpu_pkg.sv
// Shared CPU types and constants for the register file and its helpers.
package cpu_pkg;

   localparam int REG_ADDR_W = 5;
   localparam int REG_W      = 32;
   localparam int NREG       = 32;

   typedef logic [REG_ADDR_W-1:0] reg_addr_t;
   typedef logic [REG_W-1:0]      reg_data_t;

   localparam reg_addr_t REG_ZERO = 5'd0;

endpackage

// File: rtl/decoder5to32.sv
// One-hot decoder; produces an all-zero mask when disabled.
module decoder5to32
   import cpu_pkg::*;
(
   input  logic            en,
   input  reg_addr_t       addr,
   output logic [NREG-1:0] onehot
);

   always_comb begin
      onehot = '0;
      if (en) onehot[addr] = 1'b1;
   end

endmodule

// File: rtl/regfile_scoreboard.sv
// Architectural register file with write-back bypass and a pending-write
// scoreboard that flags registers still awaiting their result.
module regfile_scoreboard
   import cpu_pkg::reg_addr_t, cpu_pkg::REG_ZERO;
#(
   parameter int WIDTH = 32,
   parameter int NREG  = 32
)
(
   input  logic             clk,
   input  logic             reset_n,
   input  reg_addr_t        rd_addr_a,
   output logic [WIDTH-1:0] rd_data_a,
   output logic             rd_busy_a,
   input  reg_addr_t        rd_addr_b,
   output logic [WIDTH-1:0] rd_data_b,
   output logic             rd_busy_b,
   input  logic             issue_valid,
   input  reg_addr_t        issue_dest,
   output logic             issue_ready,
   input  logic             wb_valid,
   input  reg_addr_t        wb_addr,
   input  logic [WIDTH-1:0] wb_data,
   output logic [5:0]       pending_count
);

   logic [WIDTH-1:0] regs_q [NREG];
   logic [WIDTH-1:0] regs_d [NREG];
   logic [NREG-1:0]  pending_q, pending_d;
   logic [5:0]       count_q, count_d;
   logic [NREG-1:0]  wb_sel, iss_sel;
   logic             wb_en, iss_en, iss_inc, wb_dec;

   // Readiness looks only at the registered bitmap, never at this cycle's write-back.
   assign issue_ready = (issue_dest == REG_ZERO) || !pending_q[issue_dest];
   assign iss_en      = issue_valid && issue_ready && (issue_dest != REG_ZERO);
   assign wb_en       = wb_valid && (wb_addr != REG_ZERO);

   decoder5to32 u_wb_dec (
      .en     (wb_en),
      .addr   (wb_addr),
      .onehot (wb_sel)
   );

   decoder5to32 u_iss_dec (
      .en     (iss_en),
      .addr   (issue_dest),
      .onehot (iss_sel)
   );

   always_comb begin
      regs_d = regs_q;
      for (int i = 1; i < NREG; i++) begin
         if (wb_sel[i]) regs_d[i] = wb_data;
      end
   end

   // Set is applied after clear so a same-cycle reservation survives the write-back.
   always_comb begin
      pending_d    = (pending_q & ~wb_sel) | iss_sel;
      pending_d[0] = 1'b0;
      iss_inc      = |iss_sel;
      wb_dec       = |(wb_sel & pending_q);
      count_d      = count_q + {5'd0, iss_inc} - {5'd0, wb_dec};
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         regs_q    <= '{default: '0};
         pending_q <= '0;
         count_q   <= '0;
      end else begin
         regs_q    <= regs_d;
         pending_q <= pending_d;
         count_q   <= count_d;
      end
   end

   assign pending_count = count_q;

   always_comb begin
      rd_data_a = '0;
      rd_busy_a = 1'b0;
      if (rd_addr_a != REG_ZERO) begin
         if (wb_valid && (wb_addr == rd_addr_a)) begin
            rd_data_a = wb_data;
         end else begin
            rd_data_a = regs_q[rd_addr_a];
            rd_busy_a = pending_q[rd_addr_a];
         end
      end
   end

   always_comb begin
      rd_data_b = '0;
      rd_busy_b = 1'b0;
      if (rd_addr_b != REG_ZERO) begin
         if (wb_valid && (wb_addr == rd_addr_b)) begin
            rd_data_b = wb_data;
         end else begin
            rd_data_b = regs_q[rd_addr_b];
            rd_busy_b = pending_q[rd_addr_b];
         end
      end
   end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed self-checking bench for regfile_scoreboard.
module tb_regfile_scoreboard;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [4:0]  rd_addr_a, rd_addr_b, issue_dest, wb_addr;
   logic [31:0] rd_data_a, rd_data_b, wb_data;
   logic        rd_busy_a, rd_busy_b, issue_valid, issue_ready, wb_valid;
   logic [5:0]  pending_count;

   int checks = 0;
   int errors = 0;

   regfile_scoreboard dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .rd_addr_a     (rd_addr_a),
      .rd_data_a     (rd_data_a),
      .rd_busy_a     (rd_busy_a),
      .rd_addr_b     (rd_addr_b),
      .rd_data_b     (rd_data_b),
      .rd_busy_b     (rd_busy_b),
      .issue_valid   (issue_valid),
      .issue_dest    (issue_dest),
      .issue_ready   (issue_ready),
      .wb_valid      (wb_valid),
      .wb_addr       (wb_addr),
      .wb_data       (wb_data),
      .pending_count (pending_count)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      issue_valid = 1'b0;
      issue_dest  = 5'd0;
      wb_valid    = 1'b0;
      wb_addr     = 5'd0;
      wb_data     = 32'd0;
   endtask

   task automatic test_reset();
      reset_n   = 1'b0;
      rd_addr_a = 5'd5;
      rd_addr_b = 5'd6;
      idle();
      issue_dest = 5'd6;
      #3;
      checks++;
      if (pending_count !== 6'd0 || issue_ready !== 1'b1 || rd_busy_b !== 1'b0 || rd_data_a !== 32'd0) begin
         $display("[TB] FAIL reset_initial: count=%0d ready=%b busy=%b data=%h required 0/1/0/0",
                  pending_count, issue_ready, rd_busy_b, rd_data_a);
         errors++;
      end
      tick();
      reset_n = 1'b1;
      tick();
      wb_valid = 1'b1; wb_addr = 5'd5; wb_data = 32'hDEADBEEF;
      issue_valid = 1'b1; issue_dest = 5'd6;
      tick();
      idle();
      issue_dest = 5'd6;
      #1;
      checks++;
      if (rd_data_a !== 32'hDEADBEEF || pending_count !== 6'd1 || rd_busy_b !== 1'b1) begin
         $display("[TB] FAIL pre_reset_state: data=%h count=%0d busy6=%b required deadbeef/1/1",
                  rd_data_a, pending_count, rd_busy_b);
         errors++;
      end
      reset_n = 1'b0;
      #1;
      checks++;
      if (rd_data_a !== 32'd0 || pending_count !== 6'd0 || issue_ready !== 1'b1 || rd_busy_b !== 1'b0) begin
         $display("[TB] FAIL async_reset: data=%h count=%0d ready=%b busy6=%b required 0/0/1/0",
                  rd_data_a, pending_count, issue_ready, rd_busy_b);
         errors++;
      end
      tick();
      reset_n = 1'b1;
      idle();
      tick();
   endtask

   task automatic test_zero_reg();
      rd_addr_a = 5'd0;
      wb_valid = 1'b1; wb_addr = 5'd0; wb_data = 32'h12345678;
      #1;
      checks++;
      if (rd_data_a !== 32'd0 || rd_busy_a !== 1'b0) begin
         $display("[TB] FAIL zero_no_bypass: data=%h busy=%b required 0/0", rd_data_a, rd_busy_a);
         errors++;
      end
      tick();
      idle();
      issue_valid = 1'b1; issue_dest = 5'd0;
      #1;
      checks++;
      if (rd_data_a !== 32'd0 || issue_ready !== 1'b1) begin
         $display("[TB] FAIL zero_read_issue: data=%h ready=%b required 0/1", rd_data_a, issue_ready);
         errors++;
      end
      tick();
      idle();
      checks++;
      if (pending_count !== 6'd0) begin
         $display("[TB] FAIL zero_issue_count: count=%0d required 0", pending_count);
         errors++;
      end
   endtask

   task automatic test_bypass();
      issue_valid = 1'b1; issue_dest = 5'd7;
      tick();
      idle();
      wb_valid = 1'b1; wb_addr = 5'd7; wb_data = 32'hCAFEF00D;
      rd_addr_a = 5'd7; rd_addr_b = 5'd7;
      #1;
      checks++;
      if (rd_data_a !== 32'hCAFEF00D || rd_data_b !== 32'hCAFEF00D || rd_busy_a !== 1'b0 || rd_busy_b !== 1'b0) begin
         $display("[TB] FAIL bypass_same_cycle: a=%h b=%h busy=%b%b required cafef00d/cafef00d/00",
                  rd_data_a, rd_data_b, rd_busy_a, rd_busy_b);
         errors++;
      end
      tick();
      idle();
      checks++;
      if (rd_data_a !== 32'hCAFEF00D || rd_data_b !== 32'hCAFEF00D || rd_busy_a !== 1'b0 || pending_count !== 6'd0) begin
         $display("[TB] FAIL bypass_next_cycle: a=%h b=%h busy=%b count=%0d required cafef00d/cafef00d/0/0",
                  rd_data_a, rd_data_b, rd_busy_a, pending_count);
         errors++;
      end
   endtask

   task automatic test_scoreboard();
      issue_valid = 1'b1; issue_dest = 5'd3;
      tick();
      idle();
      rd_addr_a = 5'd3; issue_dest = 5'd3;
      #1;
      checks++;
      if (rd_busy_a !== 1'b1 || pending_count !== 6'd1 || issue_ready !== 1'b0) begin
         $display("[TB] FAIL waw_stall: busy=%b count=%0d ready=%b required 1/1/0",
                  rd_busy_a, pending_count, issue_ready);
         errors++;
      end
      issue_valid = 1'b1;
      tick();
      idle();
      checks++;
      if (pending_count !== 6'd1) begin
         $display("[TB] FAIL waw_rejected_count: count=%0d required 1", pending_count);
         errors++;
      end
      wb_valid = 1'b1; wb_addr = 5'd3; wb_data = 32'h55;
      tick();
      idle();
      issue_dest = 5'd3;
      #1;
      checks++;
      if (rd_busy_a !== 1'b0 || pending_count !== 6'd0 || issue_ready !== 1'b1 || rd_data_a !== 32'h55) begin
         $display("[TB] FAIL wb_release: busy=%b count=%0d ready=%b data=%h required 0/0/1/55",
                  rd_busy_a, pending_count, issue_ready, rd_data_a);
         errors++;
      end
   endtask

   task automatic test_simultaneous();
      issue_valid = 1'b1; issue_dest = 5'd9;
      wb_valid = 1'b1; wb_addr = 5'd9; wb_data = 32'hAA;
      #1;
      checks++;
      if (issue_ready !== 1'b1) begin
         $display("[TB] FAIL sim_ready: ready=%b required 1", issue_ready);
         errors++;
      end
      tick();
      idle();
      rd_addr_a = 5'd9;
      #1;
      checks++;
      if (rd_data_a !== 32'hAA || rd_busy_a !== 1'b1 || pending_count !== 6'd1) begin
         $display("[TB] FAIL sim_set_wins: data=%h busy=%b count=%0d required aa/1/1",
                  rd_data_a, rd_busy_a, pending_count);
         errors++;
      end
      wb_valid = 1'b1; wb_addr = 5'd9; wb_data = 32'hAB;
      tick();
      idle();
      issue_valid = 1'b1; issue_dest = 5'd2;
      tick();
      idle();
      issue_valid = 1'b1; issue_dest = 5'd4;
      wb_valid = 1'b1; wb_addr = 5'd2; wb_data = 32'h22;
      tick();
      idle();
      rd_addr_a = 5'd4; rd_addr_b = 5'd2;
      #1;
      checks++;
      if (pending_count !== 6'd1 || rd_busy_a !== 1'b1 || rd_busy_b !== 1'b0 || rd_data_b !== 32'h22) begin
         $display("[TB] FAIL sim_net_zero: count=%0d busy4=%b busy2=%b data2=%h required 1/1/0/22",
                  pending_count, rd_busy_a, rd_busy_b, rd_data_b);
         errors++;
      end
      wb_valid = 1'b1; wb_addr = 5'd4; wb_data = 32'h44;
      tick();
      idle();
      checks++;
      if (pending_count !== 6'd0) begin
         $display("[TB] FAIL sim_cleanup: count=%0d required 0", pending_count);
         errors++;
      end
   endtask

   task automatic test_fill();
      int exp_busy;
      for (int i = 1; i < 32; i++) begin
         issue_valid = 1'b1; issue_dest = 5'(i);
         tick();
         idle();
         checks++;
         if (pending_count !== 6'(i)) begin
            $display("[TB] FAIL fill_count[%0d]: count=%0d required %0d", i, pending_count, i);
            errors++;
         end
      end
      exp_busy = 0;
      for (int r = 0; r < 32; r++) begin
         rd_addr_a = 5'(r);
         #1;
         if (rd_busy_a === 1'b1) exp_busy++;
      end
      checks++;
      if (exp_busy != 31) begin
         $display("[TB] FAIL fill_busy_scan: busy regs=%0d required 31", exp_busy);
         errors++;
      end
      for (int i = 31; i >= 1; i--) begin
         wb_valid = 1'b1; wb_addr = 5'(i); wb_data = 32'(i * 3);
         tick();
         idle();
         checks++;
         if (pending_count !== 6'(i - 1)) begin
            $display("[TB] FAIL drain_count[%0d]: count=%0d required %0d", i, pending_count, i - 1);
            errors++;
         end
      end
      for (int r = 1; r < 32; r++) begin
         rd_addr_a = 5'(r);
         #1;
         checks++;
         if (rd_data_a !== 32'(r * 3) || rd_busy_a !== 1'b0) begin
            $display("[TB] FAIL drain_read[%0d]: data=%h busy=%b required %h/0",
                     r, rd_data_a, rd_busy_a, 32'(r * 3));
            errors++;
         end
      end
   endtask

   initial begin
      test_reset();
      test_zero_reg();
      test_bypass();
      test_scoreboard();
      test_simultaneous();
      test_fill();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
